fir_coeff_loader: RTL and testbench

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

---
 rtl/fir_coeff_loader.sv | 67 ++++++
 tb/tb_fir_coeff_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: buffers FIR coefficients and streams them serially into the filter between computations
module fir_coeff_loader #(
  parameter int DataWidth = 12,
  parameter int NCoeffs = 5,
  localparam int AW = NCoeffs > 1 ? $clog2(NCoeffs) : 1,
  localparam int BW = DataWidth > 1 ? $clog2(DataWidth) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  output logic                 wr_err,
  input  logic                 commit,
  input  logic                 fir_active,
  output logic                 hold_start,
  output logic                 coeff_load_in,
  output logic                 coeff_in,
  output logic                 load_done
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, SHIFT = 2'd2;
  logic [1:0] state_q, state_d;
  logic [DataWidth-1:0] buf_q [NCoeffs];
  logic [AW-1:0] idx_q, idx_d;
  logic [BW-1:0] bit_q, bit_d;
  logic rdy_q, err_q, done_q;
  logic wr_go, in_range, last;
  assign wr_go = wr_valid && wr_ready;
  assign in_range = 32'(wr_addr) < NCoeffs;
  assign last = bit_q == '0 && idx_q == '0;
  // rdy_q keeps wr_ready low through reset and the edge that releases it
  assign wr_ready = rdy_q && state_q == IDLE;
  assign wr_err = err_q;
  assign load_done = done_q;
  assign hold_start = state_q == WAIT || state_q == SHIFT;
  assign coeff_load_in = state_q == SHIFT;
  assign coeff_in = state_q == SHIFT && buf_q[idx_q][bit_q];
  always_comb begin
    state_d = (state_q == IDLE && commit) ? WAIT :
              (state_q == WAIT && !fir_active) ? SHIFT :
              ((state_q == SHIFT && last) || state_q == 2'd3) ? IDLE : state_q;
    idx_d = state_q == WAIT ? AW'(NCoeffs - 1) :
            (state_q == SHIFT && bit_q == '0) ? idx_q - 1'b1 : idx_q;
    bit_d = state_q == WAIT ? BW'(DataWidth - 1) :
            state_q == SHIFT ? (bit_q == '0 ? BW'(DataWidth - 1) : bit_q - 1'b1) : bit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      bit_q <= '0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < NCoeffs; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      bit_q <= bit_d;
      rdy_q <= 1'b1;
      err_q <= wr_go && !in_range;
      done_q <= state_q == SHIFT && last;
      if (wr_go && in_range) buf_q[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: directed scenarios for the coefficient loader with hand-computed streams
module tb_fir_coeff_loader;
  logic clk = 1'b0;
  logic rst, wr_valid, commit, fir_active;
  logic [2:0] wr_addr;
  logic [11:0] wr_data;
  logic wr_ready, wr_err, hold_start, coeff_load_in, coeff_in, load_done;
  logic [11:0] model [5];
  logic [59:0] cap;
  int checks = 0;
  int errors = 0;

  fir_coeff_loader dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .commit(commit), .fir_active(fir_active),
    .hold_start(hold_start), .coeff_load_in(coeff_load_in), .coeff_in(coeff_in),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [59:0] stream_of();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  task automatic wr(input logic [2:0] a, input logic [11:0] d);
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_valid = 1'b0;
    if (a < 3'd5) model[a] = d;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  // Starts in WAIT, ends on the load_done cycle; mid=1 injects write/commit/fir_active at bit 30
  task automatic shift_burst(input logic [59:0] exp, input int exp_wait, input bit mid, input string nm);
    int nw = 0;
    int n = 0;
    cap = '0;
    while (!coeff_load_in && nw < 100) begin
      step();
      nw++;
    end
    checks++;
    if (nw !== exp_wait) begin
      errors++;
      $display("FAIL %s wait cycles got %0d exp %0d", nm, nw, exp_wait);
    end
    while (coeff_load_in && n < 200) begin
      cap = {cap[58:0], coeff_in};
      if (mid && n == 30) begin
        checks++;
        if (wr_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s wr_ready in SHIFT got %b exp 0", nm, wr_ready);
        end
        wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 12'h123; commit = 1'b1; fir_active = 1'b1;
      end
      if (mid && n == 31) begin
        wr_valid = 1'b0; commit = 1'b0;
      end
      step();
      n++;
    end
    fir_active = 1'b0;
    checks++;
    if (n !== 60) begin
      errors++;
      $display("FAIL %s burst length got %0d exp 60", nm, n);
    end
    checks++;
    if (cap !== exp) begin
      errors++;
      $display("FAIL %s stream got %h exp %h", nm, cap, exp);
    end
    checks++;
    if ({load_done, hold_start, wr_ready} !== 3'b101) begin
      errors++;
      $display("FAIL %s done/hold/ready got %b exp 101", nm, {load_done, hold_start, wr_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({wr_ready, wr_err, hold_start, coeff_load_in, coeff_in, load_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset outputs got %b exp 000000",
               {wr_ready, wr_err, hold_start, coeff_load_in, coeff_in, load_done});
    end
    rst = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset ready_release_cycle got %b exp 0", wr_ready);
    end
    step();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset ready_after got %b exp 1", wr_ready);
    end
  endtask

  task automatic test_basic();
    wr(3'd0, 12'h7FF); wr(3'd1, 12'h001); wr(3'd2, 12'h800); wr(3'd3, 12'h555); wr(3'd4, 12'hAAA);
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL basic wr_err got %b exp 0", wr_err);
    end
    pulse_commit();
    checks++;
    if ({hold_start, coeff_load_in} !== 2'b10) begin
      errors++;
      $display("FAIL basic wait_state got %b exp 10", {hold_start, coeff_load_in});
    end
    shift_burst(60'hAAA_555_800_001_7FF, 1, 1'b0, "basic");
    step();
    checks++;
    if ({load_done, hold_start} !== 2'b00) begin
      errors++;
      $display("FAIL basic done_single got %b exp 00", {load_done, hold_start});
    end
  endtask

  task automatic test_wait_hold();
    bit bad = 1'b0;
    fir_active = 1'b1;
    pulse_commit();
    for (int i = 0; i < 20; i++) begin
      if ({hold_start, coeff_load_in} !== 2'b10) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL wait_hold hold/load during fir_active got mismatch exp 10 for 20 cycles");
    end
    fir_active = 1'b0;
    shift_burst(60'hAAA_555_800_001_7FF, 1, 1'b0, "wait_hold");
    step();
  endtask

  task automatic test_out_of_range();
    wr(3'd6, 12'h123);
    checks++;
    if (wr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor wr_err got %b exp 1", wr_err);
    end
    step();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL oor wr_err_pulse got %b exp 0", wr_err);
    end
    pulse_commit();
    shift_burst(60'hAAA_555_800_001_7FF, 1, 1'b0, "oor");
    step();
  endtask

  task automatic test_shift_ignores();
    bit bad = 1'b0;
    pulse_commit();
    shift_burst(60'hAAA_555_800_001_7FF, 1, 1'b1, "ignore");
    for (int i = 0; i < 5; i++) begin
      step();
      if ({hold_start, coeff_load_in} !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ignore second_burst got activity exp idle");
    end
  endtask

  task automatic test_same_cycle();
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 12'h0F0; commit = 1'b1;
    step();
    wr_valid = 1'b0; commit = 1'b0;
    model[2] = 12'h0F0;
    shift_burst(60'hAAA_555_0F0_001_7FF, 1, 1'b0, "same_cycle");
  endtask

  task automatic test_back_to_back();
    pulse_commit();
    checks++;
    if (hold_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b commit_on_done got %b exp 1", hold_start);
    end
    shift_burst(stream_of(), 1, 1'b0, "b2b");
    step();
  endtask

  task automatic test_reset_mid_shift();
    bit bad = 1'b0;
    pulse_commit();
    repeat (31) step();
    checks++;
    if (coeff_load_in !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid in_shift got %b exp 1", coeff_load_in);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({coeff_load_in, load_done, hold_start} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid load/done/hold got %b exp 000", {coeff_load_in, load_done, hold_start});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (load_done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_mid load_done got 1 exp 0");
    end
    for (int i = 0; i < 5; i++) model[i] = 12'h000;
    pulse_commit();
    shift_burst(60'h0, 1, 1'b0, "rst_mid");
    step();
  endtask

  // Rebuilds the filter's slots from the stream and applies an impulse x=-1 to a symmetric 9-tap filter
  task automatic test_closed_loop();
    int exp_y [9] = '{-16, 16, -256, -2047, 2048, -2047, -256, 16, -16};
    bit bad = 1'b0;
    logic signed [11:0] slot;
    int y;
    wr(3'd0, 12'h010); wr(3'd1, 12'hFF0); wr(3'd2, 12'h100); wr(3'd3, 12'h7FF); wr(3'd4, 12'h800);
    pulse_commit();
    shift_burst(stream_of(), 1, 1'b0, "closed_loop");
    for (int n = 0; n < 9; n++) begin
      slot = cap[12 * (n < 5 ? n : 8 - n) +: 12];
      y = int'(slot) * int'($signed(12'hFFF));
      if (y != exp_y[n]) begin
        bad = 1'b1;
        $display("FAIL closed_loop y[%0d] got %0d exp %0d", n, y, exp_y[n]);
      end
    end
    checks++;
    if (bad) errors++;
    step();
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; fir_active = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 12'h000;
    step();
    test_reset();
    test_basic();
    test_wait_hold();
    test_out_of_range();
    test_shift_ignores();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_shift();
    test_closed_loop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
